traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 172 +++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-way intersection phase sequencer with
// emergency preemption and an optional pedestrian walk phase.
// Optional feature macro: PED_WALK_EN (pedestrian request latch, WALK state,
// walk lamp). Without it ped_req is ignored and walk is tied low.
//
// state | meaning
// NS_G  | north-south green, east-west red
// NS_Y  | north-south yellow, east-west red
// AR    | all-red clearance, exit chosen by emergency / ped / next_dir
// EW_G  | east-west green, north-south red
// EW_Y  | east-west yellow, north-south red
// WALK  | pedestrian walk, both roads red
// EMERG | emergency hold, both roads red
module traffic_phase_scheduler #(
  parameter int GREEN_DAY   = 8,
  parameter int GREEN_NIGHT = 16,
  parameter int YELLOW      = 3,
  parameter int ALL_RED     = 1,
  parameter int WALK        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       emergency,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [2:0] S_NS_G  = 3'd0;
  localparam logic [2:0] S_NS_Y  = 3'd1;
  localparam logic [2:0] S_AR    = 3'd2;
  localparam logic [2:0] S_EW_G  = 3'd3;
  localparam logic [2:0] S_EW_Y  = 3'd4;
  localparam logic [2:0] S_WALK  = 3'd5;
  localparam logic [2:0] S_EMERG = 3'd6;

  localparam logic [4:0] LEN_DAY   = 5'(GREEN_DAY);
  localparam logic [4:0] LEN_NIGHT = 5'(GREEN_NIGHT);
  localparam logic [4:0] LEN_YEL   = 5'(YELLOW);
  localparam logic [4:0] LEN_AR    = 5'(ALL_RED);
  localparam logic [4:0] LEN_WALK  = 5'(WALK);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  logic [2:0] state, state_nxt;
  logic       next_dir, next_dir_nxt;
  logic [4:0] timer, timer_nxt;
  logic       expire;
  logic [4:0] green_len;
  logic [2:0] green_sel;
  logic       ped_pending;

  assign expire    = tick && (timer == 5'd1);
  assign green_len = night ? LEN_NIGHT : LEN_DAY;
  assign green_sel = next_dir ? S_EW_G : S_NS_G;

  // Next-state, timer and direction selection
  always_comb begin
    state_nxt    = state;
    next_dir_nxt = next_dir;
    timer_nxt    = (tick && state != S_EMERG) ? timer - 5'd1 : timer;
    case (state)
      S_NS_G: if (emergency || expire) begin
        state_nxt = S_NS_Y;
        timer_nxt = LEN_YEL;
      end
      S_NS_Y: if (expire) begin
        state_nxt    = S_AR;
        timer_nxt    = LEN_AR;
        next_dir_nxt = 1'b1;
      end
      S_EW_G: if (emergency || expire) begin
        state_nxt = S_EW_Y;
        timer_nxt = LEN_YEL;
      end
      S_EW_Y: if (expire) begin
        state_nxt    = S_AR;
        timer_nxt    = LEN_AR;
        next_dir_nxt = 1'b0;
      end
      S_AR: if (expire) begin
        if (emergency) begin
          state_nxt = S_EMERG;
          timer_nxt = LEN_AR;
`ifdef PED_WALK_EN
        end else if (ped_pending) begin
          state_nxt = S_WALK;
          timer_nxt = LEN_WALK;
`endif
        end else begin
          state_nxt = green_sel;
          timer_nxt = green_len;
        end
      end
`ifdef PED_WALK_EN
      S_WALK: if (expire) begin
        state_nxt = green_sel;
        timer_nxt = green_len;
      end
`else
      S_WALK: begin
        state_nxt = S_AR;
        timer_nxt = LEN_AR;
      end
`endif
      S_EMERG: if (tick && !emergency) begin
        state_nxt = S_NS_G;
        timer_nxt = green_len;
      end
      default: begin
        state_nxt = S_AR;
        timer_nxt = LEN_AR;
      end
    endcase
  end

  // Phase registers; reset lands in all-red heading north-south
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_AR;
      next_dir <= 1'b0;
      timer    <= LEN_AR;
    end else begin
      state    <= state_nxt;
      next_dir <= next_dir_nxt;
      timer    <= timer_nxt;
    end
  end

`ifdef PED_WALK_EN
  // Pedestrian latch: a press coinciding with WALK entry is kept for next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ped_pending <= 1'b0;
    else if (ped_req)
      ped_pending <= 1'b1;
    else if (state_nxt == S_WALK && state != S_WALK)
      ped_pending <= 1'b0;
  end
`else
  assign ped_pending = 1'b0;
  logic unused_ped_cfg;
  assign unused_ped_cfg = ^{ped_req, ped_pending, LEN_WALK};
`endif

  // Lamp decode from registered state
  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (state)
      S_NS_G:  ns_light = LAMP_GRN;
      S_NS_Y:  ns_light = LAMP_YEL;
      S_EW_G:  ew_light = LAMP_GRN;
      S_EW_Y:  ew_light = LAMP_YEL;
      default: ;
    endcase
  end

`ifdef PED_WALK_EN
  assign walk = (state == S_WALK);
`else
  assign walk = 1'b0;
`endif
  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed vector bench for traffic_phase_scheduler (default parameters).
module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_NSG = 3'd0;
  localparam logic [2:0] P_NSY = 3'd1;
  localparam logic [2:0] P_AR  = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_WLK = 3'd5;
  localparam logic [2:0] P_EMG = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, emergency, ped_req, night;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       t;
    logic       e;
    logic       p;
    logic       n;
    logic [2:0] ph;
  } vec_t;

  vec_t vq[$];

  traffic_phase_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .emergency (emergency),
    .ped_req   (ped_req),
    .night     (night),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] lamps(input logic [2:0] ph);
    case (ph)
      P_NSG:   return {3'b001, 3'b100, 1'b0};
      P_NSY:   return {3'b010, 3'b100, 1'b0};
      P_EWG:   return {3'b100, 3'b001, 1'b0};
      P_EWY:   return {3'b100, 3'b010, 1'b0};
      P_WLK:   return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic check(input string name, input int idx, input logic [2:0] ph);
    logic [6:0] exp_l;
    exp_l = lamps(ph);
    checks++;
    if (phase !== ph || {ns_light, ew_light, walk} !== exp_l) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t phase/ns/ew/walk got %0d/%b/%b/%b required %0d/%b/%b/%b",
               name, idx, $time, phase, ns_light, ew_light, walk,
               ph, exp_l[6:4], exp_l[3:1], exp_l[0]);
    end
  endtask

  task automatic add(input logic t, input logic e, input logic p, input logic n,
                     input logic [2:0] ph, input int cnt);
    vec_t v;
    v.t = t; v.e = e; v.p = p; v.n = n; v.ph = ph;
    for (int i = 0; i < cnt; i++) vq.push_back(v);
  endtask

  task automatic apply(input logic t, input logic e, input logic p, input logic n);
    tick = t; emergency = e; ped_req = p; night = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0; emergency = 1'b0; ped_req = 1'b0; night = 1'b0;

    // free run, day timing
    add(0,0,0,0,P_AR,2);
    add(1,0,0,0,P_NSG,8); add(1,0,0,0,P_NSY,3); add(1,0,0,0,P_AR,1);
    add(1,0,0,0,P_EWG,8); add(1,0,0,0,P_EWY,3); add(1,0,0,0,P_AR,1);
    // night sampled at green entry, toggling mid-green has no effect
    add(1,0,0,1,P_NSG,1); add(1,0,0,0,P_NSG,7); add(1,0,0,1,P_NSG,8);
    add(1,0,0,0,P_NSY,3); add(1,0,0,0,P_AR,1);
    add(1,0,0,0,P_EWG,8); add(1,0,0,0,P_EWY,3); add(1,0,0,0,P_AR,1);
    // tick gating in green and yellow
    add(1,0,0,0,P_NSG,2); add(0,0,0,0,P_NSG,50); add(1,0,0,0,P_NSG,6);
    add(1,0,0,0,P_NSY,1); add(0,0,0,0,P_NSY,4); add(1,0,0,0,P_NSY,2);
    add(1,0,0,0,P_AR,1);
    add(1,0,0,0,P_EWG,8); add(1,0,0,0,P_EWY,3); add(1,0,0,0,P_AR,1);
    // emergency at tick 2 of NS green
    add(1,0,0,0,P_NSG,2); add(0,1,0,0,P_NSY,1); add(1,1,0,0,P_NSY,2);
    add(1,1,0,0,P_AR,1); add(1,1,0,0,P_EMG,5); add(0,0,0,0,P_EMG,1);
    add(1,0,0,0,P_NSG,8); add(1,0,0,0,P_NSY,3); add(1,0,0,0,P_AR,1);
    // pedestrian press during EW green
    add(1,0,0,0,P_EWG,2); add(1,0,1,0,P_EWG,1); add(1,0,0,0,P_EWG,5);
    add(1,0,0,0,P_EWY,3); add(1,0,0,0,P_AR,1);
`ifdef PED_WALK_EN
    add(1,0,1,0,P_WLK,1); add(1,0,0,0,P_WLK,5);
    add(1,0,0,0,P_NSG,8); add(1,0,0,0,P_NSY,3); add(1,0,0,0,P_AR,1);
    add(1,0,0,0,P_WLK,6); add(1,0,0,0,P_EWG,1);
`else
    add(1,0,1,0,P_NSG,1); add(1,0,0,0,P_NSG,7);
    add(1,0,0,0,P_NSY,3); add(1,0,0,0,P_AR,1); add(1,0,0,0,P_EWG,1);
`endif
    // emergency preempting EW green
    add(1,0,0,0,P_EWG,2); add(0,1,0,0,P_EWY,1); add(1,0,0,0,P_EWY,2);
    add(1,0,0,0,P_AR,1); add(1,0,0,0,P_NSG,1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, P_AR);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      apply(vq[i].t, vq[i].e, vq[i].p, vq[i].n);
      check("vec", i, vq[i].ph);
    end

    // mid-phase asynchronous reset
    for (int i = 0; i < 3; i++) begin
      apply(1,0,0,0);
      check("pre_rst", i, P_NSG);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 0, P_AR);
    apply(1,0,0,0);
    check("rst_hold", 0, P_AR);
    rst_n = 1'b1;
    apply(0,0,0,0);
    check("post_rst_ar", 0, P_AR);
    for (int i = 0; i < 8; i++) begin
      apply(1,0,0,0);
      check("post_rst_nsg", i, P_NSG);
    end
    apply(1,0,0,0);
    check("post_rst_nsy", 0, P_NSY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
